// File: rtl/tff_bank_sequencer.sv
// Sequences an external bank of toggle flip-flops as a modulo-(MAX_COUNT+1) counter.
// The T inputs are driven from the fed-back Q value; tc and err are registered pulses.
module tff_bank_sequencer #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             wrap,
  input  logic             step_en,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             tc,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_LOAD,
    S_VERIFY
  } state_t;

  localparam logic [1:0]       OP_STOP = 2'b00;
  localparam logic [1:0]       OP_UP   = 2'b01;
  localparam logic [1:0]       OP_DOWN = 2'b10;
  localparam logic [1:0]       OP_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] dec_t;
  logic             at_max;
  logic             at_zero;
  logic             over;
  logic             accept;

  // Toggle masks for +1 and -1: bit i flips when all lower bits are 1 (up) or 0 (down).
  assign inc_t[0] = 1'b1;
  assign dec_t[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
    assign inc_t[gi] = &q_fb[gi-1:0];
    assign dec_t[gi] = ~|q_fb[gi-1:0];
  end

  assign at_max    = (q_fb == MAX_VAL);
  assign at_zero   = (q_fb == '0);
  assign over      = (q_fb > MAX_VAL);
  assign cmd_ready = (state == S_IDLE) || (state == S_UP) || (state == S_DOWN);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    t_out = '0;
    case (state)
      S_UP: begin
        if (step_en) begin
          if (at_max || over) t_out = wrap ? q_fb : '0;
          else                t_out = inc_t;
        end
      end
      S_DOWN: begin
        if (step_en) begin
          if (over)         t_out = q_fb ^ MAX_VAL;
          else if (at_zero) t_out = wrap ? (q_fb ^ MAX_VAL) : '0;
          else              t_out = dec_t;
        end
      end
      S_LOAD:  t_out = q_fb ^ target;
      default: t_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      target <= '0;
      tc     <= 1'b0;
      err    <= 1'b0;
    end else begin
      tc  <= 1'b0;
      err <= 1'b0;
      case (state)
        S_UP: begin
          if (step_en && (at_max || over)) begin
            tc <= 1'b1;
            if (over) err <= 1'b1;
            if (!wrap) state <= S_IDLE;
          end
        end
        S_DOWN: begin
          if (step_en) begin
            if (over) begin
              err <= 1'b1;
            end else if (at_zero) begin
              tc <= 1'b1;
              if (!wrap) state <= S_IDLE;
            end
          end
        end
        S_LOAD: state <= S_VERIFY;
        S_VERIFY: begin
          if (q_fb != target) err <= 1'b1;
          state <= S_IDLE;
        end
        default: ;
      endcase
      // An accepted command overrides any limit-driven transition of this cycle.
      if (accept) begin
        case (cmd_op)
          OP_STOP: state <= S_IDLE;
          OP_UP:   state <= S_UP;
          OP_DOWN: state <= S_DOWN;
          OP_LOAD: begin
            if (cmd_data > MAX_VAL) begin
              err <= 1'b1;
            end else begin
              target <= cmd_data;
              state  <= S_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: models the TFF bank, applies a vector table, then corner-case sequences.
module tb_tff_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       wrap;
  logic       step_en;
  logic [3:0] q_fb;
  logic [3:0] t_out;
  logic       busy;
  logic       tc;
  logic       err;

  logic [3:0] bank_q;
  logic       force_en;
  logic [3:0] force_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // The TFF bank itself: no reset, optionally preloaded by the bench.
  always @(posedge clk) begin
    if (force_en) bank_q <= force_val;
    else          bank_q <= bank_q ^ t_out;
  end
  assign q_fb = bank_q;

  tff_bank_sequencer #(.WIDTH(4), .MAX_COUNT(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .wrap      (wrap),
    .step_en   (step_en),
    .q_fb      (q_fb),
    .t_out     (t_out),
    .busy      (busy),
    .tc        (tc),
    .err       (err)
  );

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [3:0] data;
    logic       wrap;
    logic       step;
    logic [3:0] q;
    logic [3:0] t;
    logic       busy;
    logic       tc;
    logic       err;
    logic       ready;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // Count 0..9 and wrap, stop, then count down from 2 without wrap.
    vecs[0]  = '{1'b1, 2'd1, 4'd0, 1'b1, 1'b1, 4'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd2, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd3, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd4, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd5, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd6, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd7, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd8, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd9, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 4'd1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 4'd0, 1'b1, 1'b1, 4'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 2'd2, 4'd0, 1'b0, 1'b1, 4'd2, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 4'd0;
    wrap      = 1'b1;
    step_en   = 1'b1;
    force_en  = 1'b1;
    force_val = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_t_out", 32'(t_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tc", 32'(tc), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    rst_n    = 1'b1;
    force_en = 1'b0;

    for (int i = 0; i < 18; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_data  = vecs[i].data;
      wrap      = vecs[i].wrap;
      step_en   = vecs[i].step;
      @(negedge clk);
      $display("vec %0d: q=%0d t=%b busy=%b tc=%b err=%b ready=%b", i, q_fb, t_out, busy, tc, err, cmd_ready);
      check($sformatf("vec%0d_q", i), 32'(q_fb), 32'(vecs[i].q));
      check($sformatf("vec%0d_t", i), 32'(t_out), 32'(vecs[i].t));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].tc));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].ready));
    end
    cmd_valid = 1'b0;

    // LOAD 7 from a bank at 3.
    force_en  = 1'b1;
    force_val = 4'd3;
    @(negedge clk);
    force_en  = 1'b0;
    check("load_pre_q", 32'(q_fb), 32'd3);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_data  = 4'd7;
    @(negedge clk);
    $display("load cycle: t=%b ready=%b busy=%b", t_out, cmd_ready, busy);
    check("load_ready", 32'(cmd_ready), 32'd0);
    check("load_t_out", 32'(t_out), 32'b0100);
    check("load_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    $display("verify cycle: q=%0d t=%b ready=%b", q_fb, t_out, cmd_ready);
    check("verify_ready", 32'(cmd_ready), 32'd0);
    check("verify_q", 32'(q_fb), 32'd7);
    check("verify_t_out", 32'(t_out), 32'd0);
    check("verify_busy", 32'(busy), 32'd1);
    @(negedge clk);
    $display("after verify: busy=%b err=%b", busy, err);
    check("load_done_busy", 32'(busy), 32'd0);
    check("load_done_err", 32'(err), 32'd0);
    check("load_done_ready", 32'(cmd_ready), 32'd1);

    // LOAD 12 exceeds MAX_COUNT and must be rejected.
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_data  = 4'd12;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("load 12: err=%b busy=%b q=%0d", err, busy, q_fb);
    check("bad_load_err", 32'(err), 32'd1);
    check("bad_load_busy", 32'(busy), 32'd0);
    check("bad_load_q", 32'(q_fb), 32'd7);
    @(negedge clk);
    check("bad_load_err_clear", 32'(err), 32'd0);
    check("bad_load_q_hold", 32'(q_fb), 32'd7);

    // Out-of-range bank value 14 while counting up with wrap.
    force_en  = 1'b1;
    force_val = 4'd14;
    @(negedge clk);
    force_en  = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    wrap      = 1'b1;
    step_en   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("up at 14: t=%b tc=%b err=%b", t_out, tc, err);
    check("over_t_out", 32'(t_out), 32'b1110);
    check("over_tc_early", 32'(tc), 32'd0);
    @(negedge clk);
    $display("after wrap: q=%0d tc=%b err=%b", q_fb, tc, err);
    check("over_q", 32'(q_fb), 32'd0);
    check("over_tc", 32'(tc), 32'd1);
    check("over_err", 32'(err), 32'd1);
    @(negedge clk);
    check("over_tc_clear", 32'(tc), 32'd0);
    check("over_err_clear", 32'(err), 32'd0);
    check("over_next_q", 32'(q_fb), 32'd1);

    // Reset in the middle of counting at 5.
    begin
      int cycles = 0;
      while (q_fb != 4'd5 && cycles < 20) begin
        @(negedge clk);
        cycles++;
      end
      check("reach_5", 32'(q_fb), 32'd5);
    end
    rst_n   = 1'b0;
    step_en = 1'b0;
    #1;
    $display("reset mid-up: t=%b busy=%b q=%0d", t_out, busy, q_fb);
    check("midrst_t_out", 32'(t_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    step_en = 1'b1;
    @(negedge clk);
    check("midrst_q_hold", 32'(q_fb), 32'd5);
    check("midrst_t_hold", 32'(t_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_q", 32'(q_fb), 32'd5);
    step_en   = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("resume_busy", 32'(busy), 32'd1);
    check("resume_idle_t", 32'(t_out), 32'd0);
    @(negedge clk);
    check("resume_hold_q", 32'(q_fb), 32'd5);
    step_en = 1'b1;
    #1;
    check("resume_t", 32'(t_out), 32'b0011);
    @(negedge clk);
    $display("resumed: q=%0d", q_fb);
    check("resume_q", 32'(q_fb), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
